dosing_sequencer: RTL

Parametrised N-channel dosing timer, successor to the fixed three-pump R/G/B temporizador. It latches a per-channel cycle count, drives one motor per channel for that many timebase ticks in sequential or parallel mode, supports pause and abort, and reports per-channel completion flags. It sits between the count memory (keypad/RGB store) and the top-level FSM/motor outputs, and contains its own timebase so no external clock divider is needed.

---
 rtl/dosing_pkg.sv | 15 +
 rtl/dosing_tick_gen.sv | 30 +++
 rtl/dosing_sequencer.sv | 136 +++++++++++++
 3 files changed

// File: rtl/dosing_pkg.sv
// dosing_pkg: shared types for the dosing sequencer slice.
// FSM states and the mode encoding sampled on start.
package dosing_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        PAUSE,
        FINISH
    } state_t;

    localparam logic MODE_SEQ = 1'b0;
    localparam logic MODE_PAR = 1'b1;

endpackage

// File: rtl/dosing_tick_gen.sv
// tick_gen: TICK_DIV prescaler for the dosing timebase.
// clear restarts the count, hold freezes it so a partial tick survives a pause.
module tick_gen #(
    parameter int TICK_DIV = 20000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic tick
);

    localparam int W = $clog2(TICK_DIV);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    assign tick = (cnt == LAST) && !hold;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (!hold) begin
            cnt <= tick ? '0 : cnt + 1'b1;
        end
    end

endmodule

// File: rtl/dosing_sequencer.sv
// dosing_sequencer: N-channel motor dosing timer with its own timebase.
// Sequential or parallel dosing with pause, abort and sticky finish flags.
module dosing_sequencer
    import dosing_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = 5,
    parameter int TICK_DIV = 20000000,
    localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      start,
    input  logic                      abort,
    input  logic                      pause,
    input  logic                      par_mode,
    input  logic [CHANNELS*CNT_W-1:0] cycles,
    output logic [CHANNELS-1:0]       motors,
    output logic                      busy,
    output logic                      done,
    output logic                      aborted,
    output logic [CHANNELS-1:0]       flags,
    output logic [CH_W-1:0]           active_ch,
    output logic [CNT_W-1:0]          remaining
);

    state_t state, state_nx;
    logic   mode, mode_nx;
    logic   start_ok, run_ok, tick;
    logic   [CHANNELS-1:0] nz, nz_nx, dec;
    logic   [CHANNELS-1:0] first, first_nx;
    logic   [CHANNELS-1:0] flags_nx, motors_nx;
    logic   [CHANNELS-1:0][CNT_W-1:0] cnt_q;
    logic   [CH_W-1:0] idx;

    assign busy     = (state == RUN) || (state == PAUSE);
    assign done     = (state == FINISH);
    assign start_ok = (state == IDLE) && start && !abort;
    assign run_ok   = busy && tick && !pause && !abort;
    assign mode_nx  = start_ok ? par_mode : mode;

    // lowest set bit: the channel that owns the motor in sequential mode
    assign first    = nz & (~nz + 1'b1);
    assign first_nx = nz_nx & (~nz_nx + 1'b1);

    tick_gen #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk   (clk),
        .reset (reset),
        .clear (start_ok),
        .hold  (busy && pause),
        .tick  (tick)
    );

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [CNT_W-1:0] c, c_nx;

        assign nz[i]  = |c;
        assign dec[i] = run_ok && nz[i] && (mode == MODE_PAR || first[i]);
        assign c_nx   = start_ok ? cycles[i*CNT_W +: CNT_W]
                      : dec[i]   ? c - 1'b1
                      :            c;
        assign nz_nx[i]    = |c_nx;
        assign flags_nx[i] = (start_ok || dec[i]) ? !nz_nx[i] : flags[i];
        assign cnt_q[i]    = c;

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                c <= '0;
            end else begin
                c <= c_nx;
            end
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (start_ok) state_nx = (|nz_nx) ? RUN : FINISH;
            end
            RUN: begin
                if (abort)       state_nx = IDLE;
                else if (!(|nz)) state_nx = FINISH;
                else if (pause)  state_nx = PAUSE;
            end
            PAUSE: begin
                if (abort)       state_nx = IDLE;
                else if (!pause) state_nx = RUN;
            end
            FINISH:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        motors_nx = '0;
        if (state_nx == RUN) begin
            motors_nx = (mode_nx == MODE_PAR) ? nz_nx : first_nx;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            mode    <= MODE_SEQ;
            motors  <= '0;
            flags   <= '0;
            aborted <= 1'b0;
        end else begin
            state   <= state_nx;
            mode    <= mode_nx;
            motors  <= motors_nx;
            flags   <= flags_nx;
            aborted <= busy && abort;
        end
    end

    always_comb begin
        idx = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (first[i]) idx = CH_W'(i);
        end
        active_ch = '0;
        remaining = '0;
        if (busy) begin
            if (mode == MODE_PAR) begin
                for (int i = 0; i < CHANNELS; i++) begin
                    if (cnt_q[i] > remaining) remaining = cnt_q[i];
                end
            end else begin
                active_ch = idx;
                remaining = cnt_q[idx];
            end
        end
    end

endmodule
